// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I control FSM with memory handshakes, sticky trap and retire counter
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opCode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             imReady,
    input  logic             dmReady,
    output logic             imReq,
    output logic             dmReq,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RUWr,
    output logic [3:0]       ALUOp,
    output logic [2:0]       IMMSrc,
    output logic             ALUASrc,
    output logic             ALUBSrc,
    output logic             DMWr,
    output logic [2:0]       DMCtrl,
    output logic [4:0]       BrOp,
    output logic [1:0]       RUDataWrSrc,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL} cls_t;

    state_t          state, state_n;
    cls_t            cls, cls_d;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      cause_n;
    logic            to_hit;
    logic            jump;
    logic            unused_f7;

    assign unused_f7 = ^{funct7[6], funct7[4:0]};
    assign to_hit = MEM_TIMEOUT != 0 && to_cnt == TO_W'(MEM_TIMEOUT);
    assign jump = cls == C_JAL || cls == C_JALR;

    always_comb begin
        case (opCode)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            7'b1100011: cls_d = C_BRANCH;
            7'b1101111: cls_d = C_JAL;
            7'b1100111: cls_d = C_JALR;
            7'b0110111: cls_d = C_LUI;
            7'b0010111: cls_d = C_AUIPC;
            default:    cls_d = C_ILL;
        endcase
    end

    always_comb begin
        state_n     = state;
        cause_n     = 2'b00;
        imReq       = 1'b0;
        dmReq       = 1'b0;
        IRWr        = 1'b0;
        PCWr        = 1'b0;
        RUWr        = 1'b0;
        ALUOp       = 4'b0000;
        IMMSrc      = 3'b000;
        ALUASrc     = 1'b0;
        ALUBSrc     = 1'b0;
        DMWr        = 1'b0;
        DMCtrl      = 3'b000;
        BrOp        = 5'b00000;
        RUDataWrSrc = 2'b00;
        trap        = 1'b0;
        // datapath controls stay applied through MEM and WB so the ALU result remains valid
        if (state == EXEC || state == MEM || state == WB) begin
            case (cls)
                C_R:      ALUOp = {funct7[5], funct3};
                C_I:      begin ALUOp = funct3 == 3'b101 ? {funct7[5], funct3} : {1'b0, funct3}; ALUBSrc = 1'b1; end
                C_LOAD:   ALUBSrc = 1'b1;
                C_STORE:  begin ALUBSrc = 1'b1; IMMSrc = 3'b001; end
                C_BRANCH: begin ALUASrc = 1'b1; ALUBSrc = 1'b1; IMMSrc = 3'b101; BrOp = {2'b01, funct3}; end
                C_JAL:    begin ALUASrc = 1'b1; ALUBSrc = 1'b1; IMMSrc = 3'b110; end
                C_JALR:   ALUBSrc = 1'b1;
                C_LUI:    begin IMMSrc = 3'b010; ALUOp = 4'b0111; ALUBSrc = 1'b1; end
                C_AUIPC:  begin IMMSrc = 3'b010; ALUASrc = 1'b1; ALUBSrc = 1'b1; end
                default:  ;
            endcase
        end
        case (state)
            FETCH: begin
                imReq = rst_n;
                IRWr  = rst_n & imReady;
                if (imReady) state_n = DECODE;
                else if (to_hit) begin state_n = TRAP; cause_n = 2'b10; end
            end
            DECODE: begin
                state_n = cls_d == C_ILL ? TRAP : EXEC;
                cause_n = 2'b01;
            end
            EXEC: begin
                PCWr    = cls == C_BRANCH;
                state_n = (cls == C_LOAD || cls == C_STORE) ? MEM : cls == C_BRANCH ? FETCH : WB;
            end
            MEM: begin
                dmReq  = 1'b1;
                DMCtrl = funct3;
                DMWr   = cls == C_STORE;
                PCWr   = dmReady && cls == C_STORE;
                if (dmReady) state_n = cls == C_STORE ? FETCH : WB;
                else if (to_hit) begin state_n = TRAP; cause_n = 2'b11; end
            end
            WB: begin
                RUWr        = 1'b1;
                PCWr        = 1'b1;
                RUDataWrSrc = cls == C_LOAD ? 2'b01 : jump ? 2'b10 : 2'b00;
                BrOp        = jump ? 5'b10000 : 5'b00000;
                state_n     = FETCH;
            end
            default: begin
                trap    = 1'b1;
                state_n = TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            cls       <= C_ILL;
            to_cnt    <= '0;
            instret   <= '0;
            trapCause <= 2'b00;
        end else begin
            state <= state_n;
            if (state == DECODE) cls <= cls_d;
            to_cnt <= state_n != state ? '0 : (state == FETCH || state == MEM) ? to_cnt + 1'b1 : to_cnt;
            if (PCWr) instret <= instret + 1'b1;
            if (state != TRAP && state_n == TRAP) trapCause <= cause_n;
        end
    end
endmodule
